timer_evt_queue: RTL and testbench

//  Consumes the per-timer expiry outputs (time_out[TIMER_NUM-1:0]) of the global-counter timer bank.

---
 rtl/timer_evt_queue_pkg.sv | 31 +++
 rtl/timer_evt_queue_fifo.sv | 70 +++++++
 rtl/timer_evt_queue.sv | 149 ++++++++++++++
 tb/tb_timer_evt_queue.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_evt_queue_pkg.sv
// Shared types and helpers for the timer event queue.
// Optional timestamp support is enabled by defining TIMER_EVT_TIMESTAMP_EN;
// without it the FIFO entry carries only the timer ID.
package timer_evt_pkg;

  // Width of the free-running global count used for event stamps
  localparam int CNT_W    = 10;
  // Widest ID ever needed (TIMER_NUM is limited to 32)
  localparam int ID_MAX_W = 5;

  // Bits needed to encode n timer indices, never less than one
  function automatic int id_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // One queued event: timer index plus, optionally, its capture stamp
  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
`ifdef TIMER_EVT_TIMESTAMP_EN
    logic [CNT_W-1:0]    ts;
`endif
  } evt_entry_t;

  // FIFO occupancy class, derived from the level counter
  typedef enum logic [1:0] {
    FIFO_EMPTY   = 2'd0,
    FIFO_PARTIAL = 2'd1,
    FIFO_FULL    = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/timer_evt_queue_fifo.sv
// Synchronous FIFO of evt_entry_t with occupancy output.
// Entry layout depends on TIMER_EVT_TIMESTAMP_EN (see package).
// A push while full is dropped even if a pop happens in the same cycle.
module timer_evt_fifo
  import timer_evt_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  evt_entry_t    push_data,
  input  logic          pop,
  output evt_entry_t    head,
  output logic          valid,
  output logic          full,
  output logic [LW-1:0] level
);

  evt_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  fifo_state_t   state;
  logic          do_push;
  logic          do_pop;

  // Classify occupancy from the registered level
  always_comb begin
    state = FIFO_PARTIAL;
    if (level_reg == '0)
      state = FIFO_EMPTY;
    else if (level_reg == LW'(DEPTH))
      state = FIFO_FULL;
  end

  assign valid   = (state != FIFO_EMPTY);
  assign full    = (state == FIFO_FULL);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign level   = level_reg;

  // Head is zero when empty so the ID/stamp outputs read 0 out of reset
  assign head = valid ? mem[rd_ptr_reg] : '0;

  // Pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage array, written only on an accepted push
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

endmodule

// File: rtl/timer_evt_queue.sv
// Timer event queue: turns timer expiry rising edges into sticky pending
// events, arbitrates them round-robin into an ID FIFO and hands IDs to a
// consumer over valid/ready. Defining TIMER_EVT_TIMESTAMP_EN adds the
// global_cnt input and the evt_ts output carrying each event's capture stamp.
module timer_evt_queue
  import timer_evt_pkg::*;
#(
  parameter  int TIMER_NUM  = 5,
  parameter  int FIFO_DEPTH = 4,
  localparam int ID_W       = id_width(TIMER_NUM),
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [TIMER_NUM-1:0] time_out,
  output logic                 evt_valid,
  output logic [ID_W-1:0]      evt_id,
  input  logic                 evt_ready,
  output logic [TIMER_NUM-1:0] pending,
  output logic [TIMER_NUM-1:0] overrun,
  input  logic                 clr_overrun,
  output logic [LVL_W-1:0]     fifo_level
`ifdef TIMER_EVT_TIMESTAMP_EN
  ,
  input  logic [CNT_W-1:0]     global_cnt,
  output logic [CNT_W-1:0]     evt_ts
`endif
);

  logic [TIMER_NUM-1:0] prev_reg;
  logic [TIMER_NUM-1:0] pending_reg;
  logic [TIMER_NUM-1:0] overrun_reg;
  logic [ID_W-1:0]      rr_ptr_reg;
  logic [TIMER_NUM-1:0] rise;
  logic [TIMER_NUM-1:0] pending_next;
  logic [TIMER_NUM-1:0] overrun_next;
  logic [TIMER_NUM-1:0] grant_vec;
  logic [ID_W-1:0]      grant_id;
  logic                 grant_any;
  logic                 fifo_full;
  logic                 fifo_valid;
  logic                 pop;
  evt_entry_t           push_entry;
  evt_entry_t           head_entry;
  logic                 unused_id_bits;

  // Per-timer edge detect and pending/overrun next-state
  generate
    for (genvar gi = 0; gi < TIMER_NUM; gi++) begin : g_evt
      assign rise[gi] = time_out[gi] & ~prev_reg[gi];
      // A grant frees the slot; a same-cycle edge re-arms it as a new event
      assign pending_next[gi] = rise[gi] | (pending_reg[gi] & ~grant_vec[gi]);
      // Only an edge that lands on a still-pending, ungranted event is merged
      assign overrun_next[gi] = (rise[gi] & pending_reg[gi] & ~grant_vec[gi])
                              | (overrun_reg[gi] & ~clr_overrun);
    end
  endgenerate

  // Round-robin search from rr_ptr, only while the FIFO has room
  always_comb begin
    int              idx;
    logic [ID_W-1:0] idx_v;
    idx       = 0;
    idx_v     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    grant_vec = '0;
    if (!fifo_full) begin
      for (int k = 0; k < TIMER_NUM; k++) begin
        idx = int'(rr_ptr_reg) + k;
        if (idx >= TIMER_NUM) idx = idx - TIMER_NUM;
        idx_v = ID_W'(idx);
        if (!grant_any && pending_reg[idx_v]) begin
          grant_any        = 1'b1;
          grant_id         = idx_v;
          grant_vec[idx_v] = 1'b1;
        end
      end
    end
  end

  // History, pending, overrun and round-robin pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg    <= '0;
      pending_reg <= '0;
      overrun_reg <= '0;
      rr_ptr_reg  <= '0;
    end else begin
      prev_reg    <= time_out;
      pending_reg <= pending_next;
      overrun_reg <= overrun_next;
      if (grant_any)
        rr_ptr_reg <= (grant_id == ID_W'(TIMER_NUM - 1)) ? '0 : grant_id + 1'b1;
    end
  end

`ifdef TIMER_EVT_TIMESTAMP_EN
  logic [CNT_W-1:0] ts_reg [TIMER_NUM];

  // Stamp a timer on a fresh event; merged edges keep the original stamp
  generate
    for (genvar gi = 0; gi < TIMER_NUM; gi++) begin : g_ts
      // Capture global_cnt when the edge starts a new event for this timer
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          ts_reg[gi] <= '0;
        else if (rise[gi] & (~pending_reg[gi] | grant_vec[gi]))
          ts_reg[gi] <= global_cnt;
      end
    end
  endgenerate
`endif

  // Build the FIFO entry for the granted timer
  always_comb begin
    push_entry    = '0;
    push_entry.id = ID_MAX_W'(grant_id);
`ifdef TIMER_EVT_TIMESTAMP_EN
    push_entry.ts = ts_reg[grant_id];
`endif
  end

  assign pop = fifo_valid & evt_ready;

  timer_evt_fifo #(
    .DEPTH     (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (grant_any),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .valid     (fifo_valid),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign evt_valid      = fifo_valid;
  assign evt_id         = head_entry.id[ID_W-1:0];
  assign unused_id_bits = ^head_entry.id;
  assign pending        = pending_reg;
  assign overrun        = overrun_reg;
`ifdef TIMER_EVT_TIMESTAMP_EN
  assign evt_ts         = head_entry.ts;
`endif

endmodule

// File: tb/tb_timer_evt_queue.sv
// Self-checking bench for timer_evt_queue (TIMER_NUM=5, FIFO_DEPTH=4).
// Timestamp scenario runs when TIMER_EVT_TIMESTAMP_EN is defined.
module tb_timer_evt_queue;
  localparam int N     = 5;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] time_out = '0;
  logic         evt_valid;
  logic [2:0]   evt_id;
  logic         evt_ready = 1'b0;
  logic [N-1:0] pending;
  logic [N-1:0] overrun;
  logic         clr_overrun = 1'b0;
  logic [2:0]   fifo_level;
`ifdef TIMER_EVT_TIMESTAMP_EN
  logic [9:0]   global_cnt = 10'h155;
  logic [9:0]   evt_ts;
`endif

  int errs   = 0;
  int checks = 0;

  timer_evt_queue #(.TIMER_NUM(N), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .time_out    (time_out),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .pending     (pending),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .fifo_level  (fifo_level)
`ifdef TIMER_EVT_TIMESTAMP_EN
    ,
    .global_cnt  (global_cnt),
    .evt_ts      (evt_ts)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_prev [N];
  bit m_pend [N];
  bit m_ovr  [N];
  int m_ts   [N];
  int m_rr;
  int m_q_id [$];
  int m_q_ts [$];

  function automatic int vec(input bit b [N]);
    int v = 0;
    for (int i = 0; i < N; i++) if (b[i]) v |= (1 << i);
    return v;
  endfunction

  // Advance the model over the posedge just passed, then compare every cycle
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        for (int i = 0; i < N; i++) begin
          m_prev[i] = 0; m_pend[i] = 0; m_ovr[i] = 0; m_ts[i] = 0;
        end
        m_rr = 0;
        m_q_id.delete();
        m_q_ts.delete();
      end else begin
        int sz;
        int g;
        bit e;
        sz = m_q_id.size();
        g  = -1;
        if (sz < DEPTH) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (g < 0 && m_pend[j]) g = j;
          end
        end
        if (sz > 0 && evt_ready) begin
          void'(m_q_id.pop_front());
          void'(m_q_ts.pop_front());
        end
        if (g >= 0) begin
          m_q_id.push_back(g);
          m_q_ts.push_back(m_ts[g]);
          m_rr = (g + 1) % N;
        end
        for (int i = 0; i < N; i++) begin
          e = time_out[i] && !m_prev[i];
          if (e && m_pend[i] && i != g) m_ovr[i] = 1;
          else if (clr_overrun)         m_ovr[i] = 0;
`ifdef TIMER_EVT_TIMESTAMP_EN
          if (e && (!m_pend[i] || i == g)) m_ts[i] = int'(global_cnt);
`endif
          if (e)           m_pend[i] = 1;
          else if (i == g) m_pend[i] = 0;
          m_prev[i] = time_out[i];
        end
      end
      chk("cyc_valid",   int'(evt_valid),  int'(m_q_id.size() > 0));
      chk("cyc_id",      int'(evt_id),     (m_q_id.size() > 0) ? m_q_id[0] : 0);
      chk("cyc_level",   int'(fifo_level), m_q_id.size());
      chk("cyc_pending", int'(pending),    vec(m_pend));
      chk("cyc_overrun", int'(overrun),    vec(m_ovr));
`ifdef TIMER_EVT_TIMESTAMP_EN
      chk("cyc_ts",      int'(evt_ts),     (m_q_ts.size() > 0) ? m_q_ts[0] : 0);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    time_out = '0; evt_ready = 1'b0; clr_overrun = 1'b0;
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step(1);
  endtask

  initial begin
    int got [$];
    int n_evt;
    int last_id;
    int vcnt;
    bit stalled;

    step(2);
    $display("reset: valid=%0b level=%0d pending=%b", evt_valid, fifo_level, pending);
    chk("rst_valid",   int'(evt_valid),  0);
    chk("rst_level",   int'(fifo_level), 0);
    chk("rst_pending", int'(pending),    0);
    rst_n = 1'b1;
    step(1);

    // 1: single rise on timer 2
    time_out = 5'b00100; evt_ready = 1'b1;
    step(1);
    chk("t1_pending", int'(pending), 5'b00100);
    chk("t1_valid0",  int'(evt_valid), 0);
    step(1);
    time_out = '0;
    $display("t1: valid=%0b id=%0d pending=%b", evt_valid, evt_id, pending);
    chk("t1_valid", int'(evt_valid), 1);
    chk("t1_id",    int'(evt_id), 2);
    chk("t1_clear", int'(pending), 0);
    step(1);
    chk("t1_once", int'(evt_valid), 0);

    // 2/3: all five at once, stalled consumer, then re-rise on timer 4
    do_reset();
    time_out = 5'b11111;
    step(1);
    chk("t2_pend_all", int'(pending), 5'b11111);
    time_out = '0;
    step(4);
    $display("t2: level=%0d pending=%b head=%0d", fifo_level, pending, evt_id);
    chk("t2_level",   int'(fifo_level), 4);
    chk("t2_pending", int'(pending), 5'b10000);
    chk("t2_head",    int'(evt_id), 0);
    time_out = 5'b10000;
    step(1);
    time_out = '0;
    chk("t3_overrun", int'(overrun), 5'b10000);
    clr_overrun = 1'b1;
    step(1);
    clr_overrun = 1'b0;
    chk("t3_clr", int'(overrun), 0);
    evt_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (evt_valid) begin
        got.push_back(int'(evt_id));
        $display("t2: delivered id=%0d", evt_id);
      end
      step(1);
    end
    chk("t2_count", got.size(), 5);
    for (int i = 0; i < got.size() && i < 5; i++) chk("t2_order", got[i], i);

    // 4: level held high, consumer stalls intermittently
    do_reset();
    time_out = 5'b00010;
    n_evt = 0; stalled = 0; last_id = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (stalled) begin
        chk("t4_stall_valid", int'(evt_valid), 1);
        chk("t4_stall_id",    int'(evt_id), last_id);
      end
      evt_ready = (i % 4 == 3);
      if (evt_valid && evt_ready) begin
        n_evt++;
        chk("t4_id", int'(evt_id), 1);
      end
      stalled = evt_valid && !evt_ready;
      last_id = int'(evt_id);
    end
    time_out = '0;
    step(3);
    $display("t4: events=%0d", n_evt);
    chk("t4_events", n_evt, 1);

    // 5: reset in the middle of activity
    do_reset();
    time_out = 5'b11111;
    step(1);
    time_out = '0;
    step(3);
    chk("t5_level",   int'(fifo_level), 3);
    chk("t5_pending", int'(pending), 5'b11000);
    rst_n = 1'b0;
    #1;
    $display("t5: async reset valid=%0b level=%0d pending=%b", evt_valid, fifo_level, pending);
    chk("t5_rst_valid", int'(evt_valid), 0);
    chk("t5_rst_level", int'(fifo_level), 0);
    chk("t5_rst_pend",  int'(pending), 0);
    chk("t5_rst_id",    int'(evt_id), 0);
    step(2);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (evt_valid) vcnt++;
    end
    chk("t5_no_replay", vcnt, 0);

`ifdef TIMER_EVT_TIMESTAMP_EN
    // 6: stamps across the count wrap
    do_reset();
    global_cnt = 10'h3FF; time_out = 5'b00001;
    step(1);
    global_cnt = 10'h000; time_out = 5'b01000;
    step(1);
    time_out = '0; global_cnt = 10'h123;
    step(2);
    chk("t6_id0", int'(evt_id), 0);
    chk("t6_ts0", int'(evt_ts), 10'h3FF);
    evt_ready = 1'b1;
    step(1);
    $display("t6: id=%0d ts=%0h", evt_id, evt_ts);
    chk("t6_id3", int'(evt_id), 3);
    chk("t6_ts3", int'(evt_ts), 10'h000);
    step(2);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
